// File: rtl/cordic_pkg.sv
// Shared constants, channel ids and FSM encoding for the CORDIC front-end arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cordic_pkg;

  localparam int CORDIC_IN_W     = 16;
  localparam int CORDIC_OUT_W    = 16;
  localparam int CORDIC_CORE_LAT = 8;

  // Legal rotation angle range in integer degrees.
  localparam int ANGLE_P180 = 180;
  localparam int ANGLE_N180 = -180;

  // Channel ids carried in the tag pipeline; CH_ATAN doubles as the core mode bit.
  localparam logic CH_ROT  = 1'b0;
  localparam logic CH_ATAN = 1'b1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cordic_tag_pipe.sv
// Tag shift register tracking which channel owns each result in flight in the core.
// Latency: a pushed tag reaches the tail DEPTH cycles after the push cycle.
// Backpressure: none; shifts every cycle.
// Ports: i_push_vld/i_push_ch enter at the head; o_tail_vld/o_tail_ch leave at the tail;
//        o_any_vld is set while any stage holds a valid tag.
module cordic_tag_pipe
  import cordic_pkg::*;
#(
  parameter int DEPTH = CORDIC_CORE_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push_vld,
  input  logic i_push_ch,
  output logic o_tail_vld,
  output logic o_tail_ch,
  output logic o_any_vld
);

  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_ch  <= '0;
    end else begin
      r_vld[0] <= i_push_vld;
      r_ch[0]  <= i_push_ch;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_ch[i]  <= r_ch[i-1];
      end
    end
  end

  assign o_tail_vld = r_vld[DEPTH-1];
  assign o_tail_ch  = r_ch[DEPTH-1];
  assign o_any_vld  = |r_vld;

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter feeding one shared CORDIC core from a rotation and an arctan requester,
// routing each core result back to its owner. Latency: 1 + CORE_LATENCY cycles request->response.
// Backpressure: only the granted channel sees ready; responses have no backpressure; flush drains.
// Ports: rot_*/atan_* requester handshakes, core_* core issue/result, rot/atan_rsp_valid + rsp_data
//        routed result, flush/flush_done drain control, busy/err_tag/err_range status.
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int INPUT_WIDTH  = CORDIC_IN_W,
  parameter int OUTPUT_WIDTH = CORDIC_OUT_W,
  parameter int CORE_LATENCY = CORDIC_CORE_LAT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rot_valid,
  output logic                    rot_ready,
  input  logic [INPUT_WIDTH-1:0]  rot_degree,
  input  logic                    atan_valid,
  output logic                    atan_ready,
  input  logic [INPUT_WIDTH-1:0]  atan_tan,
  output logic [INPUT_WIDTH-1:0]  core_degree,
  output logic [INPUT_WIDTH-1:0]  core_tan,
  output logic                    core_arctan_en,
  output logic                    core_valid,
  input  logic [OUTPUT_WIDTH-1:0] core_result,
  input  logic                    core_result_valid,
  output logic [OUTPUT_WIDTH-1:0] rsp_data,
  output logic                    rot_rsp_valid,
  output logic                    atan_rsp_valid,
  input  logic                    flush,
  output logic                    flush_done,
  output logic                    busy,
  output logic                    err_tag,
  output logic                    err_range
);

  localparam logic signed [INPUT_WIDTH-1:0] P180_W = INPUT_WIDTH'(ANGLE_P180);
  localparam logic signed [INPUT_WIDTH-1:0] N180_W = INPUT_WIDTH'(ANGLE_N180);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic                   r_ptr;
  logic                   w_rot_gnt;
  logic                   w_atan_gnt;
  logic                   w_deg_hi;
  logic                   w_deg_lo;
  logic [INPUT_WIDTH-1:0] w_deg_clamped;
  logic                   w_tail_vld;
  logic                   w_tail_ch;
  logic                   w_tag_any;
  logic                   w_hit;

  logic                   r_core_valid;
  logic [INPUT_WIDTH-1:0] r_core_degree;
  logic [INPUT_WIDTH-1:0] r_core_tan;
  logic                   r_core_arctan_en;
  logic                   r_err_tag;
  logic                   r_err_range;

  assign w_deg_hi      = $signed(rot_degree) > P180_W;
  assign w_deg_lo      = $signed(rot_degree) < N180_W;
  assign w_deg_clamped = w_deg_hi ? P180_W : (w_deg_lo ? N180_W : rot_degree);

  assign busy = r_core_valid | w_tag_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Grant only in RUN and never in the cycle flush is seen, so a drain
  // starts with no new issue behind it.
  always_comb begin
    w_state_nxt = r_state;
    w_rot_gnt   = 1'b0;
    w_atan_gnt  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (flush) begin
          w_state_nxt = ST_DRAIN;
        end else if (rot_valid && (!atan_valid || r_ptr == CH_ROT)) begin
          w_rot_gnt = 1'b1;
        end else if (atan_valid) begin
          w_atan_gnt = 1'b1;
        end
      end
      ST_DRAIN: if (!busy)  w_state_nxt = ST_DONE;
      ST_DONE:  if (!flush) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  assign rot_ready  = w_rot_gnt;
  assign atan_ready = w_atan_gnt;
  assign flush_done = (r_state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr            <= CH_ROT;
      r_core_valid     <= 1'b0;
      r_core_degree    <= '0;
      r_core_tan       <= '0;
      r_core_arctan_en <= 1'b0;
      r_err_tag        <= 1'b0;
      r_err_range      <= 1'b0;
    end else begin
      r_core_valid <= w_rot_gnt | w_atan_gnt;
      if (w_rot_gnt) begin
        r_ptr            <= CH_ATAN;
        r_core_degree    <= w_deg_clamped;
        r_core_tan       <= '0;
        r_core_arctan_en <= 1'b0;
        if (w_deg_hi || w_deg_lo) r_err_range <= 1'b1;
      end else if (w_atan_gnt) begin
        r_ptr            <= CH_ROT;
        r_core_degree    <= '0;
        r_core_tan       <= atan_tan;
        r_core_arctan_en <= 1'b1;
      end
      // A result with no owner, or an owner with no result, means the core
      // latency no longer matches the tag pipeline.
      if (w_tail_vld != core_result_valid) r_err_tag <= 1'b1;
    end
  end

  assign core_valid     = r_core_valid;
  assign core_degree    = r_core_degree;
  assign core_tan       = r_core_tan;
  assign core_arctan_en = r_core_arctan_en;
  assign err_tag        = r_err_tag;
  assign err_range      = r_err_range;

  // Tags are pushed from the registered issue so the tail lines up with
  // core_result_valid exactly CORE_LATENCY cycles after core_valid.
  cordic_tag_pipe #(
    .DEPTH(CORE_LATENCY)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push_vld(r_core_valid),
    .i_push_ch (r_core_arctan_en ? CH_ATAN : CH_ROT),
    .o_tail_vld(w_tail_vld),
    .o_tail_ch (w_tail_ch),
    .o_any_vld (w_tag_any)
  );

  assign w_hit          = w_tail_vld & core_result_valid;
  assign rot_rsp_valid  = w_hit & (w_tail_ch == CH_ROT);
  assign atan_rsp_valid = w_hit & (w_tail_ch == CH_ATAN);
  assign rsp_data       = w_hit ? core_result : '0;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter with a behavioural fixed-latency core model.
// Stimulus pushes expected responses; a negedge monitor pops and compares them.
module tb_cordic_arbiter;
  import cordic_pkg::*;

  localparam int IW  = 16;
  localparam int OW  = 16;
  localparam int LAT = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rot_valid, rot_ready, atan_valid, atan_ready;
  logic [IW-1:0] rot_degree, atan_tan, core_degree, core_tan;
  logic          core_arctan_en, core_valid, core_result_valid;
  logic [OW-1:0] core_result, rsp_data;
  logic          rot_rsp_valid, atan_rsp_valid;
  logic          flush, flush_done, busy, err_tag, err_range;

  always #5 clk = ~clk;

  cordic_arbiter #(
    .INPUT_WIDTH (IW),
    .OUTPUT_WIDTH(OW),
    .CORE_LATENCY(LAT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rot_valid        (rot_valid),
    .rot_ready        (rot_ready),
    .rot_degree       (rot_degree),
    .atan_valid       (atan_valid),
    .atan_ready       (atan_ready),
    .atan_tan         (atan_tan),
    .core_degree      (core_degree),
    .core_tan         (core_tan),
    .core_arctan_en   (core_arctan_en),
    .core_valid       (core_valid),
    .core_result      (core_result),
    .core_result_valid(core_result_valid),
    .rsp_data         (rsp_data),
    .rot_rsp_valid    (rot_rsp_valid),
    .atan_rsp_valid   (atan_rsp_valid),
    .flush            (flush),
    .flush_done       (flush_done),
    .busy             (busy),
    .err_tag          (err_tag),
    .err_range        (err_range)
  );

  // Core model: result appears LAT cycles after core_valid.
  // rotation -> degree + 1000, arctan -> tan ^ 16'h5A5A.
  logic [LAT-1:0] cm_vld;
  logic [OW-1:0]  cm_dat [LAT];
  logic           inj;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_vld <= '0;
      for (int i = 0; i < LAT; i++) cm_dat[i] <= '0;
    end else begin
      cm_vld    <= {cm_vld[LAT-2:0], core_valid};
      cm_dat[0] <= core_arctan_en ? (core_tan ^ 16'h5A5A) : (core_degree + 16'd1000);
      for (int i = 1; i < LAT; i++) cm_dat[i] <= cm_dat[i-1];
    end
  end

  assign core_result_valid = cm_vld[LAT-1] | inj;
  assign core_result       = cm_dat[LAT-1];

  typedef struct {
    logic        ch;
    logic [15:0] dat;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: any response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rot_rsp_valid || atan_rsp_valid) begin
      if (rot_rsp_valid && atan_rsp_valid) chk("rsp_both_valid", 32'd1, 32'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: rot=%0b atan=%0b data=%0h with nothing outstanding (cycle %0d)",
                 rot_rsp_valid, atan_rsp_valid, rsp_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_channel", {31'd0, atan_rsp_valid}, {31'd0, mon_e.ch});
        chk("rsp_data", {16'd0, rsp_data}, {16'd0, mon_e.dat});
        chk("rsp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  function automatic logic [15:0] clamp(input logic [15:0] d);
    if ($signed(d) > 16'sd180)  return 16'd180;
    if ($signed(d) < -16'sd180) return 16'hFF4C;
    return d;
  endfunction

  // Reference arbitration state.
  logic        m_ptr;
  logic        m_prev_vld, m_prev_ch;
  logic [15:0] m_prev_deg, m_prev_tan;
  logic        s_fd, s_rr;
  int          s_cyc;

  // One cycle: drive at posedge+1, check at negedge, return at next posedge+1.
  task automatic step(input logic rv, input logic [15:0] rd, input logic av,
                      input logic [15:0] at, input logic fl, input logic allow);
    logic eg_r, eg_a;
    exp_t e;
    rot_valid  = rv;
    rot_degree = rd;
    atan_valid = av;
    atan_tan   = at;
    flush      = fl;
    @(negedge clk);
    chk("core_valid", {31'd0, core_valid}, {31'd0, m_prev_vld});
    if (m_prev_vld) begin
      chk("core_arctan_en", {31'd0, core_arctan_en}, {31'd0, m_prev_ch});
      chk("core_degree", {16'd0, core_degree}, {16'd0, m_prev_deg});
      chk("core_tan", {16'd0, core_tan}, {16'd0, m_prev_tan});
    end
    eg_r = allow && rv && (!av || m_ptr == CH_ROT);
    eg_a = allow && av && !eg_r;
    chk("rot_ready", {31'd0, rot_ready}, {31'd0, eg_r});
    chk("atan_ready", {31'd0, atan_ready}, {31'd0, eg_a});
    m_prev_vld = eg_r || eg_a;
    if (eg_r) begin
      m_prev_ch  = CH_ROT;
      m_prev_deg = clamp(rd);
      m_prev_tan = 16'd0;
      e.ch  = CH_ROT;
      e.dat = clamp(rd) + 16'd1000;
      e.cyc = cyc + LAT + 1;
      sb.push_back(e);
      m_ptr = CH_ATAN;
    end else if (eg_a) begin
      m_prev_ch  = CH_ATAN;
      m_prev_deg = 16'd0;
      m_prev_tan = at;
      e.ch  = CH_ATAN;
      e.dat = at ^ 16'h5A5A;
      e.cyc = cyc + LAT + 1;
      sb.push_back(e);
      m_ptr = CH_ROT;
    end
    s_fd  = flush_done;
    s_rr  = rot_ready;
    s_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int   last_exp;
    logic fd_seen;

    rst_n = 1'b0; rot_valid = 1'b0; atan_valid = 1'b0; rot_degree = '0; atan_tan = '0;
    flush = 1'b0; inj = 1'b0;
    m_ptr = CH_ROT; m_prev_vld = 1'b0; m_prev_ch = 1'b0; m_prev_deg = '0; m_prev_tan = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_core_valid", {31'd0, core_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
    chk("rst_err_tag", {31'd0, err_tag}, 32'd0);
    chk("rst_err_range", {31'd0, err_range}, 32'd0);
    chk("rst_core_degree", {16'd0, core_degree}, 32'd0);
    chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention: grants alternate starting with rotation.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'(10 * (i + 1)), 1'b1, 16'(16'h0100 + i), 1'b0, 1'b1);
      chk("alt_grant_rot", {31'd0, s_rr}, {31'd0, (i % 2) == 0});
    end
    chk("busy_inflight", {31'd0, busy}, 32'd1);
    idle(12);
    chk("busy_idle", {31'd0, busy}, 32'd0);

    // Rotation only, back to back.
    for (int i = 0; i < 6; i++) step(1'b1, 16'd45, 1'b0, 16'd0, 1'b0, 1'b1);
    idle(12);

    // Range: -180 passes unflagged; 200 and -300 clamp and flag.
    step(1'b1, 16'hFF4C, 1'b0, 16'd0, 1'b0, 1'b1);
    idle(2);
    chk("err_range_n180", {31'd0, err_range}, 32'd0);
    step(1'b1, 16'd200, 1'b0, 16'd0, 1'b0, 1'b1);
    idle(1);
    chk("err_range_200", {31'd0, err_range}, 32'd1);
    step(1'b1, 16'hFED4, 1'b0, 16'd0, 1'b0, 1'b1);
    idle(12);
    chk("err_range_sticky", {31'd0, err_range}, 32'd1);

    // Flush with three in flight.
    for (int i = 1; i <= 3; i++) step(1'b1, 16'(i), 1'b0, 16'd0, 1'b0, 1'b1);
    last_exp = sb[sb.size()-1].cyc;
    fd_seen  = 1'b0;
    for (int k = 0; k < 30 && !fd_seen; k++) begin
      step(1'b1, 16'd77, 1'b0, 16'd0, 1'b1, 1'b0);
      if (s_fd) begin
        fd_seen = 1'b1;
        chk("flush_done_pending", sb.size(), 32'd0);
        chk("flush_done_cycle", s_cyc, last_exp + 2);
      end
    end
    chk("flush_done_seen", {31'd0, fd_seen}, 32'd1);
    step(1'b1, 16'd77, 1'b0, 16'd0, 1'b0, 1'b0);
    step(1'b1, 16'd77, 1'b0, 16'd0, 1'b0, 1'b1);
    chk("flush_done_clear", {31'd0, s_fd}, 32'd0);
    idle(12);

    // Orphan result with an empty pipe.
    chk("err_tag_before", {31'd0, err_tag}, 32'd0);
    inj = 1'b1;
    step(1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b1);
    inj = 1'b0;
    chk("err_tag_set", {31'd0, err_tag}, 32'd1);
    idle(3);
    chk("err_tag_sticky", {31'd0, err_tag}, 32'd1);

    // Reset with four in flight.
    for (int i = 5; i <= 8; i++) step(1'b1, 16'(i), 1'b0, 16'd0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_core_valid", {31'd0, core_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_core_degree", {16'd0, core_degree}, 32'd0);
    chk("mid_rst_err_tag", {31'd0, err_tag}, 32'd0);
    chk("mid_rst_err_range", {31'd0, err_range}, 32'd0);
    sb.delete();
    m_ptr = CH_ROT;
    m_prev_vld = 1'b0;
    rot_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(15);
    step(1'b1, 16'd30, 1'b1, 16'h0055, 1'b0, 1'b1);
    chk("post_rst_first_rot", {31'd0, s_rr}, 32'd1);
    idle(12);
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
